// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Ports: clk, rst_n, A, B, op, start, flush -> ready, busy, res_valid, res. Option: MULDIV_FAST_MUL_EN.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   op,
  input  logic         start,
  input  logic         flush,
  output logic         ready,
  output logic         busy,
  output logic         res_valid,
  output logic [N-1:0] res
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e          state_q;
  logic [2:0]      op_q;
  logic [N-1:0]    m_q;
  logic [2*N-1:0]  prod_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic            ready_q;
  logic            busy_q;
  logic            valid_q;
  logic [N-1:0]    res_q;

  logic            is_div;
  logic            sa;
  logic            sb;
  logic            neg_d;
  logic [N-1:0]    amag;
  logic [N-1:0]    bmag;
  logic            div0;
  logic            ovf;
  logic [N-1:0]    sp_res;

  // Accept-time decode: operand magnitudes, result sign, special cases.
  always_comb begin
    is_div = op[2];
    sa     = is_div ? !op[0] : (op[1:0] != 2'b11);
    sb     = is_div ? !op[0] : !op[1];
    amag   = (sa && A[N-1]) ? -A : A;
    bmag   = (sb && B[N-1]) ? -B : B;
    if (is_div && op[1])
      neg_d = sa & A[N-1];
    else
      neg_d = (sa & A[N-1]) ^ (sb & B[N-1]);
    div0   = is_div && (B == '0);
    ovf    = is_div && !op[0] && (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
    if (div0)
      sp_res = op[1] ? A : '1;
    else
      sp_res = op[1] ? '0 : A;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*N-1:0] ax;
  logic [2*N-1:0] bx;
  logic [2*N-1:0] fprod;
  logic [N-1:0]   fast_res;

  // Sign-extended operands: low 2N bits match the (N+1)x(N+1) signed product.
  always_comb begin
    ax       = {{N{sa & A[N-1]}}, A};
    bx       = {{N{sb & B[N-1]}}, B};
    fprod    = ax * bx;
    fast_res = (op[1:0] == 2'b00) ? fprod[N-1:0] : fprod[2*N-1:N];
  end
`endif

  logic [N:0]     mul_sum;
  logic [N:0]     shifted;
  logic [N:0]     diff;
  logic [2*N-1:0] step_nxt;
  logic [2*N-1:0] pfull;
  logic [N-1:0]   fix_res;

  // prod_q holds {acc, multiplier} for mul and {rem, quotient} for div.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, m_q} : '0);
    shifted = {prod_q[2*N-1:N], prod_q[N-1]};
    diff    = shifted - {1'b0, m_q};
    if (op_q[2]) begin
      if (diff[N])
        step_nxt = {shifted[N-1:0], prod_q[N-2:0], 1'b0};
      else
        step_nxt = {diff[N-1:0], prod_q[N-2:0], 1'b1};
    end else begin
      step_nxt = {mul_sum, prod_q[N-1:1]};
    end
    pfull = neg_q ? -prod_q : prod_q;
    if (op_q[2]) begin
      if (op_q[1])
        fix_res = neg_q ? -prod_q[2*N-1:N] : prod_q[2*N-1:N];
      else
        fix_res = neg_q ? -prod_q[N-1:0] : prod_q[N-1:0];
    end else begin
      fix_res = (op_q[1:0] == 2'b00) ? pfull[N-1:0] : pfull[2*N-1:N];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      m_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (start) begin
              op_q  <= op;
              neg_q <= neg_d;
              cnt_q <= '0;
              if (div0 || ovf) begin
                res_q   <= sp_res;
                valid_q <= 1'b1;
                state_q <= DONE;
              end
`ifdef MULDIV_FAST_MUL_EN
              else if (!is_div) begin
                res_q   <= fast_res;
                valid_q <= 1'b1;
                state_q <= DONE;
              end
`endif
              else begin
                m_q     <= is_div ? bmag : amag;
                prod_q  <= {{N{1'b0}}, is_div ? amag : bmag};
                state_q <= CALC;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
            end else begin
              state_q <= IDLE;
            end
          end
          CALC: begin
            prod_q <= step_nxt;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LAST)
              state_q <= FIX;
          end
          FIX: begin
            res_q   <= fix_res;
            valid_q <= 1'b1;
            state_q <= DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res       = res_q;

endmodule
